fpu_minmax_cmp_pipe: RTL and testbench

Parametrised, pipelined floating-point min/max/compare unit for the FPU arithmetic cluster. It generalises the combinational min/max path in four ways: configurable exponent/mantissa widths, FMIN/FMAX/FEQ/FLT/FLE modes, a configurable pipeline depth, and a valid/ready handshake with flush. It sits between FPU operand issue and FPU writeback arbitration, and carries an opaque tag for writeback routing.

---
 rtl/fpu_minmax_cmp_pipe.sv | 157 +++++++++++++++
 tb/tb_fpu_minmax_cmp_pipe.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_minmax_cmp_pipe.sv
// Pipelined floating-point min/max/compare unit with valid/ready handshake,
// synchronous flush and tag pass-through for writeback routing.
module fpu_minmax_cmp_pipe #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned MAN_W  = 23,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 5
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [2:0]               op_i,
    input  logic [EXP_W+MAN_W:0]     a_i,
    input  logic [EXP_W+MAN_W:0]     b_i,
    input  logic [TAG_W-1:0]         tag_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [EXP_W+MAN_W:0]     result_o,
    output logic                     nv_o,
    output logic [TAG_W-1:0]         tag_o
);

    localparam int unsigned W = 1 + EXP_W + MAN_W;

    localparam logic [2:0] OP_FMIN = 3'b000;
    localparam logic [2:0] OP_FMAX = 3'b001;
    localparam logic [2:0] OP_FEQ  = 3'b010;
    localparam logic [2:0] OP_FLT  = 3'b011;
    localparam logic [2:0] OP_FLE  = 3'b100;

    localparam logic [W-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // Total order on non-NaN encodings with -0 below +0.
    function automatic logic lt_total(input logic [W-1:0] x, input logic [W-1:0] y);
        logic r;
        if (x[W-1] != y[W-1]) begin
            r = x[W-1];
        end else if (x[W-1]) begin
            r = (x[W-2:0] > y[W-2:0]);
        end else begin
            r = (x[W-2:0] < y[W-2:0]);
        end
        return r;
    endfunction

    logic a_nan, b_nan, a_snan, b_snan, any_nan, any_snan;
    logic a_lt_b, b_lt_a, both_zero, cmp_eq, cmp_lt;
    logic [W-1:0] res_d;
    logic         nv_d;

    assign a_nan     = (&a_i[W-2:MAN_W]) & (|a_i[MAN_W-1:0]);
    assign b_nan     = (&b_i[W-2:MAN_W]) & (|b_i[MAN_W-1:0]);
    assign a_snan    = a_nan & ~a_i[MAN_W-1];
    assign b_snan    = b_nan & ~b_i[MAN_W-1];
    assign any_nan   = a_nan | b_nan;
    assign any_snan  = a_snan | b_snan;
    assign a_lt_b    = lt_total(a_i, b_i);
    assign b_lt_a    = lt_total(b_i, a_i);
    assign both_zero = (a_i[W-2:0] == '0) && (b_i[W-2:0] == '0);
    assign cmp_eq    = (a_i == b_i) | both_zero;
    assign cmp_lt    = a_lt_b & ~both_zero;

    // Stage-1 result and invalid flag.
    always_comb begin
        res_d = '0;
        nv_d  = 1'b0;
        case (op_i)
            OP_FMIN, OP_FMAX: begin
                nv_d = any_snan;
                if (a_nan && b_nan) begin
                    res_d = CANON_NAN;
                end else if (a_nan) begin
                    res_d = b_i;
                end else if (b_nan) begin
                    res_d = a_i;
                end else if (op_i == OP_FMIN) begin
                    res_d = b_lt_a ? b_i : a_i;
                end else begin
                    res_d = a_lt_b ? b_i : a_i;
                end
            end
            OP_FEQ: begin
                res_d = W'(cmp_eq & ~any_nan);
                nv_d  = any_snan;
            end
            OP_FLT: begin
                res_d = W'(cmp_lt & ~any_nan);
                nv_d  = any_nan;
            end
            OP_FLE: begin
                res_d = W'((cmp_lt | cmp_eq) & ~any_nan);
                nv_d  = any_nan;
            end
            default: begin
                res_d = '0;
                nv_d  = 1'b0;
            end
        endcase
    end

    logic             valid_q [STAGES];
    logic [W-1:0]     res_q   [STAGES];
    logic             nv_q    [STAGES];
    logic [TAG_W-1:0] tag_q   [STAGES];
    logic [STAGES-1:0] stage_en;
    logic             en_acc;

    // A stage may load when it, or any stage after it, has a hole, or the sink accepts.
    always_comb begin
        stage_en = '0;
        en_acc   = ready_i;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            en_acc      = en_acc | ~valid_q[k];
            stage_en[k] = en_acc;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                valid_q[k] <= 1'b0;
                res_q[k]   <= '0;
                nv_q[k]    <= 1'b0;
                tag_q[k]   <= '0;
            end
        end else begin
            if (stage_en[0]) begin
                valid_q[0] <= valid_i;
                res_q[0]   <= res_d;
                nv_q[0]    <= nv_d;
                tag_q[0]   <= tag_i;
            end
            for (int k = 1; k < int'(STAGES); k++) begin
                if (stage_en[k]) begin
                    valid_q[k] <= valid_q[k-1];
                    res_q[k]   <= res_q[k-1];
                    nv_q[k]    <= nv_q[k-1];
                    tag_q[k]   <= tag_q[k-1];
                end
            end
            if (flush_i) begin
                for (int k = 0; k < int'(STAGES); k++) begin
                    valid_q[k] <= 1'b0;
                end
            end
        end
    end

    assign ready_o  = stage_en[0];
    assign valid_o  = valid_q[STAGES-1];
    assign result_o = res_q[STAGES-1];
    assign nv_o     = nv_q[STAGES-1];
    assign tag_o    = tag_q[STAGES-1];

endmodule

// File: tb/tb_fpu_minmax_cmp_pipe.sv
// Directed bench: FP32 unit with three stages plus a one-stage half-precision unit.
module tb_fpu_minmax_cmp_pipe;

    localparam logic [2:0] FMIN = 3'b000;
    localparam logic [2:0] FMAX = 3'b001;
    localparam logic [2:0] FEQ  = 3'b010;
    localparam logic [2:0] FLT  = 3'b011;
    localparam logic [2:0] FLE  = 3'b100;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        nv;
    } vec_t;

    typedef struct packed {
        logic [31:0] res;
        logic        nv;
        logic [4:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush, valid_i, ready_i, ready_o, valid_o, nv;
    logic [2:0]  op;
    logic [31:0] a, b, result;
    logic [4:0]  tag, tag_o;

    logic        h_valid_i, h_ready_i, h_ready_o, h_valid_o, h_nv;
    logic [2:0]  h_op;
    logic [15:0] h_a, h_b, h_result;
    logic [4:0]  h_tag, h_tag_o;

    int checks = 0;
    int errors = 0;

    fpu_minmax_cmp_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(3), .TAG_W(5)) dut (
        .clk_i(clk), .reset_i(reset), .flush_i(flush), .valid_i(valid_i), .ready_o(ready_o),
        .op_i(op), .a_i(a), .b_i(b), .tag_i(tag), .valid_o(valid_o), .ready_i(ready_i),
        .result_o(result), .nv_o(nv), .tag_o(tag_o)
    );

    fpu_minmax_cmp_pipe #(.EXP_W(5), .MAN_W(10), .STAGES(1), .TAG_W(5)) dut_h (
        .clk_i(clk), .reset_i(reset), .flush_i(flush), .valid_i(h_valid_i), .ready_o(h_ready_o),
        .op_i(h_op), .a_i(h_a), .b_i(h_b), .tag_i(h_tag), .valid_o(h_valid_o), .ready_i(h_ready_i),
        .result_o(h_result), .nv_o(h_nv), .tag_o(h_tag_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] r, input logic n);
        vec_t v;
        v.op = o; v.a = x; v.b = y; v.res = r; v.nv = n;
        return v;
    endfunction

    vec_t vecs[$];
    exp_t sb[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int sent, recv, cyc;
        logic stalled, stale_seen;
        logic [31:0] held_res;
        logic held_nv;
        logic [4:0] held_tag;
        exp_t e;

        vecs.push_back(mk(FMIN, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0));
        vecs.push_back(mk(FMAX, 32'h00000000, 32'h80000000, 32'h00000000, 1'b0));
        vecs.push_back(mk(FMAX, 32'h7FA00000, 32'h3F800000, 32'h3F800000, 1'b1));
        vecs.push_back(mk(FMIN, 32'h7FC00001, 32'hFFC00000, 32'h7FC00000, 1'b0));
        vecs.push_back(mk(FEQ,  32'h7FC00000, 32'h3F800000, 32'h00000000, 1'b0));
        vecs.push_back(mk(FLT,  32'h7FC00000, 32'h3F800000, 32'h00000000, 1'b1));
        vecs.push_back(mk(FLE,  32'h80000000, 32'h00000000, 32'h00000001, 1'b0));
        vecs.push_back(mk(FLT,  32'hBF800000, 32'h3F800000, 32'h00000001, 1'b0));
        vecs.push_back(mk(FEQ,  32'h80000000, 32'h00000000, 32'h00000001, 1'b0));
        vecs.push_back(mk(FLT,  32'h80000000, 32'h00000000, 32'h00000000, 1'b0));
        vecs.push_back(mk(FEQ,  32'h7F800001, 32'h00000000, 32'h00000000, 1'b1));
        vecs.push_back(mk(FMIN, 32'h3F800000, 32'h40000000, 32'h3F800000, 1'b0));
        vecs.push_back(mk(FMAX, 32'hBF800000, 32'hC0000000, 32'hBF800000, 1'b0));
        vecs.push_back(mk(FMIN, 32'hBF800000, 32'hC0000000, 32'hC0000000, 1'b0));
        vecs.push_back(mk(3'b101, 32'h3F800000, 32'h40000000, 32'h00000000, 1'b0));
        vecs.push_back(mk(FMIN, 32'h7F800001, 32'hFF800001, 32'h7FC00000, 1'b1));
        vecs.push_back(mk(FLE,  32'h3F800000, 32'h3F800000, 32'h00000001, 1'b0));
        vecs.push_back(mk(FLT,  32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0));
        vecs.push_back(mk(FMAX, 32'h7F800000, 32'h7F7FFFFF, 32'h7F800000, 1'b0));
        vecs.push_back(mk(FMIN, 32'h7FC00000, 32'hFF800000, 32'hFF800000, 1'b0));
        vecs.push_back(mk(FEQ,  32'h3F800000, 32'h3F800000, 32'h00000001, 1'b0));

        reset = 1'b1; flush = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        op = '0; a = '0; b = '0; tag = '0;
        h_valid_i = 1'b0; h_ready_i = 1'b1; h_op = '0; h_a = '0; h_b = '0; h_tag = '0;

        repeat (3) @(negedge clk);
        check("reset valid_o", 32'(valid_o), 32'd0);
        check("reset result_o", result, 32'd0);
        check("reset nv_o", 32'(nv), 32'd0);
        check("reset tag_o", 32'(tag_o), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("ready after reset", 32'(ready_o), 32'd1);

        // Table vectors, one op at a time, latency checked on each.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            valid_i = 1'b1; op = vecs[i].op; a = vecs[i].a; b = vecs[i].b; tag = 5'(i);
            @(negedge clk);
            valid_i = 1'b0;
            n = 1;
            while (!valid_o && n < 10) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("vec%0d latency", i), 32'(n), 32'd3);
            check($sformatf("vec%0d result", i), result, vecs[i].res);
            check($sformatf("vec%0d nv", i), 32'(nv), 32'(vecs[i].nv));
            check($sformatf("vec%0d tag", i), 32'(tag_o), 32'(i));
        end

        // Half precision.
        @(negedge clk);
        h_valid_i = 1'b1; h_op = FMAX; h_a = 16'h3C00; h_b = 16'hBC00; h_tag = 5'd7;
        @(negedge clk);
        check("half fmax valid", 32'(h_valid_o), 32'd1);
        check("half fmax result", 32'(h_result), 32'h3C00);
        check("half fmax tag", 32'(h_tag_o), 32'd7);
        h_op = FMIN; h_a = 16'h7C01; h_b = 16'hFE00; h_tag = 5'd8;
        @(negedge clk);
        h_valid_i = 1'b0;
        check("half fmin nan result", 32'(h_result), 32'h7E00);
        check("half fmin nan nv", 32'(h_nv), 32'd1);
        @(negedge clk);
        check("half idle valid", 32'(h_valid_o), 32'd0);

        // Streaming: ten back-to-back ops.
        repeat (4) @(negedge clk);
        for (cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            if (cyc >= 3 && cyc < 13) begin
                check($sformatf("stream valid c%0d", cyc), 32'(valid_o), 32'd1);
                check($sformatf("stream tag c%0d", cyc), 32'(tag_o), 32'(cyc - 3));
                check($sformatf("stream result c%0d", cyc), result,
                      (cyc - 3 > 5) ? 32'(cyc - 3) : 32'd5);
            end else begin
                check($sformatf("stream idle c%0d", cyc), 32'(valid_o), 32'd0);
            end
            if (cyc < 10) begin
                valid_i = 1'b1; op = FMAX; a = 32'(cyc); b = 32'd5; tag = 5'(cyc);
            end else begin
                valid_i = 1'b0;
            end
        end

        // Random valid/backpressure against the vector table.
        sent = 0; recv = 0; cyc = 0; stalled = 1'b0;
        held_res = '0; held_nv = 1'b0; held_tag = '0;
        while ((sent < 1000 || recv < 1000) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            valid_i = (sent < 1000) ? 1'($urandom_range(1)) : 1'b0;
            ready_i = 1'($urandom_range(1));
            begin
                int idx;
                idx = int'($urandom_range(vecs.size() - 1));
                op = vecs[idx].op; a = vecs[idx].a; b = vecs[idx].b; tag = 5'(sent);
                e.res = vecs[idx].res; e.nv = vecs[idx].nv; e.tag = 5'(sent);
            end
            #1;
            if (stalled) begin
                check("stall valid held", 32'(valid_o), 32'd1);
                check("stall result stable", result, held_res);
                check("stall nv stable", 32'(nv), 32'(held_nv));
                check("stall tag stable", 32'(tag_o), 32'(held_tag));
            end
            if (valid_o && ready_i) begin
                if (sb.size() == 0) begin
                    check("bp unexpected output", 32'(valid_o), 32'd0);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    check("bp result", result, x.res);
                    check("bp nv", 32'(nv), 32'(x.nv));
                    check("bp tag", 32'(tag_o), 32'(x.tag));
                end
                recv++;
            end
            stalled = valid_o & ~ready_i;
            held_res = result; held_nv = nv; held_tag = tag_o;
            if (valid_i && ready_o) begin
                sb.push_back(e);
                sent++;
            end
        end
        valid_i = 1'b0;
        check("bp received count", 32'(recv), 32'd1000);
        check("bp scoreboard empty", 32'(sb.size()), 32'd0);

        // Flush with the pipeline full.
        @(negedge clk);
        ready_i = 1'b0; valid_i = 1'b1; op = FMAX; a = 32'h3F800000; b = '0; tag = 5'd21;
        repeat (5) @(negedge clk);
        check("full before flush valid_o", 32'(valid_o), 32'd1);
        check("full before flush ready_o", 32'(ready_o), 32'd0);
        flush = 1'b1;
        #1;
        check("ready_o during flush", 32'(ready_o), 32'd0);
        @(negedge clk);
        flush = 1'b0; valid_i = 1'b0;
        check("valid_o after flush", 32'(valid_o), 32'd0);
        ready_i = 1'b1;
        stale_seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            stale_seen = stale_seen | valid_o;
        end
        // Input transferring in the same cycle as flush is dropped.
        valid_i = 1'b1; flush = 1'b1; tag = 5'd22;
        #1;
        check("ready_o flush empty pipe", 32'(ready_o), 32'd1);
        @(negedge clk);
        valid_i = 1'b0; flush = 1'b0;
        repeat (6) begin
            @(negedge clk);
            stale_seen = stale_seen | valid_o;
        end
        check("no stale result after flush", 32'(stale_seen), 32'd0);

        // Reset mid-operation.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            valid_i = 1'b1; op = FMIN; a = 32'h40000000; b = 32'h40400000; tag = 5'(i + 1);
        end
        @(negedge clk);
        valid_i = 1'b0;
        check("pre-reset valid_o", 32'(valid_o), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async reset valid_o", 32'(valid_o), 32'd0);
        check("async reset result_o", result, 32'd0);
        check("async reset nv_o", 32'(nv), 32'd0);
        check("async reset tag_o", 32'(tag_o), 32'd0);
        @(negedge clk);
        reset = 1'b0; ready_i = 1'b0;
        #1;
        check("ready_o after mid-op reset", 32'(ready_o), 32'd1);
        ready_i = 1'b1;
        stale_seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            stale_seen = stale_seen | valid_o;
        end
        check("no op survives reset", 32'(stale_seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
